// File: rtl/demux_1xn_stream_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package demux_1xn_stream_pkg;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_1xn_stream_if.sv
// Handshake bundle between the upstream source, the demux and its N consumers.
interface demux_1xn_stream_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
);
  import demux_1xn_stream_pkg::*;

  logic [WIDTH-1:0]          in_data;
  logic [SELW-1:0]           in_sel;
  logic                      in_bcast;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic                      sel_err;
  logic [DROP_W-1:0]         drop_cnt;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err, drop_cnt
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err, drop_cnt
  );

endinterface

// File: rtl/demux_chan_slot.sv
// One-entry valid/ready holding register for a single output channel.
module demux_chan_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             free
);

  assign free = !out_valid || out_ready;

  // Load beats drain, so a slot can take a new word every cycle; data is kept after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N demux: select decode, accept logic, drop reporting and per-channel slots.
module demux_1xn_stream
  import demux_1xn_stream_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1xn_stream_if.slave  bus
);

  logic [CHANNELS-1:0]       sel_hit;
  logic [CHANNELS-1:0]       free;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*WIDTH-1:0] slot_data;
  logic [CHANNELS-1:0]       slot_valid;
  logic                      in_range;
  logic                      all_free;
  logic                      in_ready;
  logic                      accept;
  logic                      drop;
  logic                      sel_err;
  logic [DROP_W-1:0]         drop_cnt;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < CHANNELS; k++) sel_hit[k] = (bus.in_sel == SELW'(k));
  end

  assign in_range = |sel_hit;
  assign all_free = &free;

  // Broadcast waits for every slot so it is never partially delivered.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (bus.in_bcast)  in_ready = all_free;
      else if (in_range) in_ready = |(sel_hit & free);
      else               in_ready = 1'b1;
    end
  end

  assign accept = bus.in_valid & in_ready;
  assign load   = !accept     ? {CHANNELS{1'b0}} :
                  bus.in_bcast ? {CHANNELS{1'b1}} : sel_hit;
  assign drop   = accept & ~bus.in_bcast & ~in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= drop;
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    demux_chan_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (bus.in_data),
      .out_data  (slot_data[k*WIDTH +: WIDTH]),
      .out_valid (slot_valid[k]),
      .out_ready (bus.out_ready[k]),
      .free      (free[k])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = slot_data;
  assign bus.out_valid = slot_valid;
  assign bus.sel_err   = sel_err;
  assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: a 4-channel and a 3-channel instance share stimulus and a slot-level model.
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_1xn_stream_if #(.WIDTH(16), .CHANNELS(4), .SELW(2)) bus4 ();
  demux_1xn_stream_if #(.WIDTH(16), .CHANNELS(3), .SELW(2)) bus3 ();

  demux_1xn_stream #(.WIDTH(16), .CHANNELS(4), .SELW(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  demux_1xn_stream #(.WIDTH(16), .CHANNELS(3), .SELW(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  logic [15:0] t_data;
  logic [1:0]  t_sel;
  logic        t_bcast, t_valid;
  logic [3:0]  t_ordy;

  assign bus4.in_data   = t_data;
  assign bus4.in_sel    = t_sel;
  assign bus4.in_bcast  = t_bcast;
  assign bus4.in_valid  = t_valid;
  assign bus4.out_ready = t_ordy;
  assign bus3.in_data   = t_data;
  assign bus3.in_sel    = t_sel;
  assign bus3.in_bcast  = t_bcast;
  assign bus3.in_valid  = t_valid;
  assign bus3.out_ready = t_ordy[2:0];

  logic        a_rdy   [2];
  logic [3:0]  a_valid [2];
  logic [63:0] a_data  [2];
  logic        a_err   [2];
  logic [7:0]  a_cnt   [2];

  always_comb begin
    a_rdy[0]   = bus4.in_ready;
    a_rdy[1]   = bus3.in_ready;
    a_valid[0] = bus4.out_valid;
    a_valid[1] = {1'b0, bus3.out_valid};
    a_data[0]  = bus4.out_data;
    a_data[1]  = {16'h0000, bus3.out_data};
    a_err[0]   = bus4.sel_err;
    a_err[1]   = bus3.sel_err;
    a_cnt[0]   = bus4.drop_cnt;
    a_cnt[1]   = bus3.drop_cnt;
  end

  int          nch [2] = '{4, 3};
  bit          m_full [2][4];
  logic [15:0] m_word [2][4];
  bit          m_err  [2];
  int          m_cnt  [2];
  int          x_act  [2][4];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (%0d-ch): got %0h, expected %0h", name, nch[d], act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      m_cnt[d] = 0;
      for (int k = 0; k < 4; k++) begin
        m_full[d][k] = 1'b0;
        m_word[d][k] = 16'h0000;
      end
    end
  endtask

  function automatic bit exp_ready(input int d);
    bit allf = 1'b1;
    if (!rst_n) return 1'b0;
    for (int k = 0; k < nch[d]; k++) if (m_full[d][k] && !t_ordy[k]) allf = 1'b0;
    if (t_bcast) return allf;
    if (int'(t_sel) < nch[d]) return !m_full[d][t_sel] || t_ordy[t_sel];
    return 1'b1;
  endfunction

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    bit acc [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      bit e;
      e = exp_ready(d);
      chk("in_ready", d, 64'(a_rdy[d]), 64'(e));
      acc[d] = t_valid && e;
      for (int k = 0; k < nch[d]; k++) if (a_valid[d][k] && t_ordy[k]) x_act[d][k]++;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nch[d]; k++) if (m_full[d][k] && t_ordy[k]) m_full[d][k] = 1'b0;
      m_err[d] = 1'b0;
      if (acc[d]) begin
        if (t_bcast) begin
          for (int k = 0; k < nch[d]; k++) begin
            m_full[d][k] = 1'b1;
            m_word[d][k] = t_data;
          end
        end else if (int'(t_sel) < nch[d]) begin
          m_full[d][t_sel] = 1'b1;
          m_word[d][t_sel] = t_data;
        end else begin
          m_err[d] = 1'b1;
          if (m_cnt[d] < 255) m_cnt[d]++;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [3:0]  ev;
      logic [63:0] ed;
      ev = '0;
      ed = '0;
      for (int k = 0; k < nch[d]; k++) begin
        ev[k] = m_full[d][k];
        ed[k*16 +: 16] = m_word[d][k];
      end
      chk("out_valid", d, 64'(a_valid[d]), 64'(ev));
      chk("out_data",  d, a_data[d], ed);
      chk("sel_err",   d, 64'(a_err[d]), 64'(m_err[d]));
      chk("drop_cnt",  d, 64'(a_cnt[d]), 64'(m_cnt[d]));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [1:0]  sel;
    logic        bcast;
    logic        valid;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    int          ch;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vt [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    vt[0] = '{16'hA5A5, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0100, 2, 16'hA5A5};
    vt[1] = '{16'hA5A5, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0100, 2, 16'hA5A5};
    vt[2] = '{16'h1111, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0101, 0, 16'h1111};
    vt[3] = '{16'h1234, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0101, 0, 16'h1111};
    vt[4] = '{16'h1234, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0101, 0, 16'h1234};
    vt[5] = '{16'h0000, 2'd0, 1'b0, 1'b0, 4'b0101, 1'b1, 4'b0000, 0, 16'h1234};
    vt[6] = '{16'h3333, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1000, 3, 16'h3333};
    vt[7] = '{16'hBEEF, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1000, 3, 16'h3333};
    vt[8] = '{16'hBEEF, 2'd0, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1111, 1, 16'hBEEF};
    vt[9] = '{16'h0000, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 2, 16'hBEEF};

    t_data = '0; t_sel = '0; t_bcast = 1'b0; t_valid = 1'b0; t_ordy = '0;
    model_reset();
    for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) x_act[d][k] = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", d, 64'(a_valid[d]), 64'd0);
      chk("reset_data",  d, a_data[d], 64'd0);
      chk("reset_err",   d, 64'(a_err[d]), 64'd0);
      chk("reset_cnt",   d, 64'(a_cnt[d]), 64'd0);
      chk("reset_ready", d, 64'(a_rdy[d]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // unicast, stall, drain-and-load, broadcast blocked then released
    for (int i = 0; i < 10; i++) begin
      t_data = vt[i].data; t_sel = vt[i].sel; t_bcast = vt[i].bcast;
      t_valid = vt[i].valid; t_ordy = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d_ready", i), 0, 64'(a_rdy[0]), 64'(vt[i].exp_rdy));
      step();
      chk($sformatf("vec%0d_valid", i), 0, 64'(a_valid[0]), 64'(vt[i].exp_valid));
      chk($sformatf("vec%0d_data", i), 0, 64'(a_data[0][vt[i].ch*16 +: 16]), 64'(vt[i].exp_data));
    end

    // back-to-back streaming on channel 1
    x0 = x_act[0][1];
    t_ordy = 4'b0010; t_bcast = 1'b0; t_sel = 2'd1; t_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      t_data = 16'(i);
      #1;
      chk("stream_ready", 0, 64'(a_rdy[0]), 64'd1);
      step();
      chk("stream_data", 0, 64'(a_data[0][31:16]), 64'(i));
    end
    t_valid = 1'b0;
    step();
    chk("stream_xfers", 0, 64'(x_act[0][1] - x0), 64'd8);
    chk("stream_empty", 0, 64'(a_valid[0][1]), 64'd0);

    // out-of-range select on the 3-channel instance
    do_reset();
    t_ordy = 4'b1111; t_bcast = 1'b0; t_sel = 2'd3; t_data = 16'hDEAD; t_valid = 1'b1;
    step();
    chk("drop_err",   1, 64'(a_err[1]), 64'd1);
    chk("drop_cnt1",  1, 64'(a_cnt[1]), 64'd1);
    chk("drop_valid", 1, 64'(a_valid[1]), 64'd0);
    t_valid = 1'b0;
    step();
    chk("drop_err_clr", 1, 64'(a_err[1]), 64'd0);
    t_valid = 1'b1;
    repeat (300) step();
    chk("drop_sat", 1, 64'(a_cnt[1]), 64'd255);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      t_data  = 16'($urandom);
      t_sel   = 2'($urandom_range(0, 3));
      t_bcast = ($urandom_range(0, 3) == 0);
      t_valid = 1'($urandom_range(0, 1));
      t_ordy  = 4'($urandom);
      step();
    end

    // async reset with slots full, between clock edges
    t_ordy = 4'b1111; t_bcast = 1'b1; t_valid = 1'b1; t_data = 16'hC0DE;
    step();
    t_valid = 1'b0; t_ordy = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_valid", d, 64'(a_valid[d]), 64'd0);
      chk("async_data",  d, a_data[d], 64'd0);
      chk("async_ready", d, 64'(a_rdy[d]), 64'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
